// File: rtl/vga_sync_receiver.sv
`timescale 1ns/1ps
// vga_sync_receiver: sink side of the VGA timing path. Samples HS/VS on the
// pixel strobe, locks onto the line/frame timing and recovers the pixel
// position, active-video flag, lock status and a saturating lock-loss count.
//
// state    | meaning
// SEARCH   | no timing reference yet, waiting for a VS fall
// VERIFY   | counting consecutive clean frames toward lock
// LOCKED   | timing trusted, coordinates valid; any error drops to SEARCH
module vga_sync_receiver #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       CLK,
   input  logic       RST_BTN,
   input  logic       i_pix_stb,
   input  logic       i_hs,
   input  logic       i_vs,
   output logic [9:0] o_x,
   output logic [8:0] o_y,
   output logic       o_active,
   output logic       o_frame_start,
   output logic       o_locked,
   output logic [7:0] o_err_cnt
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] C_H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] C_V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] C_HA0    = 10'(H_SYNC + H_BP);
   localparam logic [9:0] C_HA_END = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0] C_VA0    = 10'(V_SYNC + V_BP);
   localparam logic [9:0] C_VA_END = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [3:0] C_LOCK   = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_VERIFY = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t     r_state, w_state_nxt;
   logic       r_hs_prev, r_vs_prev, r_frame_bad, r_frame_start;
   logic [9:0] r_hcnt, r_lcnt, w_hcnt_nxt, w_lcnt_nxt;
   logic [3:0] r_good, w_good_nxt;
   logic [7:0] r_err_cnt, w_err_nxt;
   logic       w_hs_fall, w_vs_fall, w_line_err, w_frame_err;
   logic       w_in_h, w_in_v;

   assign w_hs_fall   = r_hs_prev & ~i_hs;
   assign w_vs_fall   = r_vs_prev & ~i_vs;
   // A line must end exactly at H_TOTAL-1: early fall or timeout are both errors.
   assign w_line_err  = w_hs_fall ? (r_hcnt != C_H_LAST) : (r_hcnt == C_H_LAST);
   assign w_frame_err = w_vs_fall ? (r_lcnt != C_V_LAST) : (w_hs_fall & (r_lcnt == C_V_LAST));

   // Next position: VS fall restarts the frame ahead of the HS line increment.
   always_comb begin
      w_hcnt_nxt = r_hcnt;
      w_lcnt_nxt = r_lcnt;
      if (w_hs_fall)
         w_hcnt_nxt = '0;
      else if (r_hcnt != 10'h3FF)
         w_hcnt_nxt = r_hcnt + 10'd1;
      if (w_vs_fall)
         w_lcnt_nxt = '0;
      else if (w_hs_fall && (r_lcnt != 10'h3FF))
         w_lcnt_nxt = r_lcnt + 10'd1;
   end

   // Sampled sync levels, position counters and the per-frame error flag.
   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN) begin
         r_hs_prev     <= 1'b0;
         r_vs_prev     <= 1'b0;
         r_hcnt        <= '0;
         r_lcnt        <= '0;
         r_frame_bad   <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= i_pix_stb & w_vs_fall;
         if (i_pix_stb) begin
            r_hs_prev   <= i_hs;
            r_vs_prev   <= i_vs;
            r_hcnt      <= w_hcnt_nxt;
            r_lcnt      <= w_lcnt_nxt;
            r_frame_bad <= w_vs_fall ? 1'b0 : (r_frame_bad | w_line_err);
         end
      end
   end

   // Lock FSM state register with good-frame and lock-loss counters.
   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN) begin
         r_state   <= S_SEARCH;
         r_good    <= '0;
         r_err_cnt <= '0;
      end else if (i_pix_stb) begin
         r_state   <= w_state_nxt;
         r_good    <= w_good_nxt;
         r_err_cnt <= w_err_nxt;
      end
   end

   // Lock FSM next state; frame_bad is the value accumulated before this strobe.
   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_err_nxt   = r_err_cnt;
      case (r_state)
         S_SEARCH: begin
            if (w_vs_fall) begin
               w_state_nxt = S_VERIFY;
               w_good_nxt  = '0;
            end
         end
         S_VERIFY: begin
            if (w_vs_fall) begin
               if (!w_frame_err && !r_frame_bad) begin
                  w_good_nxt = r_good + 4'd1;
                  if ((r_good + 4'd1) == C_LOCK)
                     w_state_nxt = S_LOCKED;
               end else begin
                  w_good_nxt = '0;
               end
            end
         end
         S_LOCKED: begin
            if (w_line_err || w_frame_err) begin
               w_state_nxt = S_SEARCH;
               if (r_err_cnt != 8'hFF)
                  w_err_nxt = r_err_cnt + 8'd1;
            end
         end
         default: w_state_nxt = S_SEARCH;
      endcase
   end

   assign w_in_h        = (r_hcnt >= C_HA0) && (r_hcnt < C_HA_END);
   assign w_in_v        = (r_lcnt >= C_VA0) && (r_lcnt < C_VA_END);
   assign o_locked      = (r_state == S_LOCKED);
   assign o_active      = o_locked & w_in_h & w_in_v;
   assign o_x           = o_active ? (r_hcnt - C_HA0) : 10'd0;
   assign o_y           = o_active ? 9'(r_lcnt - C_VA0) : 9'd0;
   assign o_frame_start = r_frame_start;
   assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_vga_sync_receiver.sv
`timescale 1ns/1ps
// Bench for vga_sync_receiver using a reduced 8x6 timing so that lock,
// loss and 256 lock losses fit in a short run.
module tb_vga_sync_receiver;
   localparam int HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int LF = 2;
   localparam int HT = HA + HF + HS + HB;   // 8
   localparam int VT = VA + VF + VS + VB;   // 6
   localparam int HA0 = HS + HB;            // 3
   localparam int VA0 = VS + VB;            // 2

   logic       CLK = 1'b0;
   logic       RST_BTN;
   logic       i_pix_stb, i_hs, i_vs;
   logic [9:0] o_x;
   logic [8:0] o_y;
   logic       o_active, o_frame_start, o_locked;
   logic [7:0] o_err_cnt;

   vga_sync_receiver #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .LOCK_FRAMES(LF)
   ) dut (
      .CLK(CLK), .RST_BTN(RST_BTN), .i_pix_stb(i_pix_stb),
      .i_hs(i_hs), .i_vs(i_vs),
      .o_x(o_x), .o_y(o_y), .o_active(o_active),
      .o_frame_start(o_frame_start), .o_locked(o_locked), .o_err_cnt(o_err_cnt)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;
   bit cmp_en = 1'b0;
   int gap = 4;

   // Reference: position within line/frame, lock phase (0 search, 1 verify, 2 locked).
   int   m_h, m_l, m_phase, m_good, m_err;
   logic m_hp, m_vp, m_bad, m_fs;
   bit   t_hf, t_vf, t_le, t_fe;
   bit   e_lk, e_act;
   int   e_x, e_y;

   always_comb begin
      t_hf = m_hp && !i_hs;
      t_vf = m_vp && !i_vs;
      t_le = t_hf ? (m_h != HT - 1) : (m_h == HT - 1);
      t_fe = t_vf ? (m_l != VT - 1) : (t_hf && m_l == VT - 1);
      e_lk  = (m_phase == 2);
      e_act = e_lk && m_h >= HA0 && m_h < HA0 + HA && m_l >= VA0 && m_l < VA0 + VA;
      e_x   = e_act ? m_h - HA0 : 0;
      e_y   = e_act ? m_l - VA0 : 0;
   end

   always @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN) begin
         m_h <= 0; m_l <= 0; m_phase <= 0; m_good <= 0; m_err <= 0;
         m_hp <= 1'b0; m_vp <= 1'b0; m_bad <= 1'b0; m_fs <= 1'b0;
      end else begin
         m_fs <= i_pix_stb && t_vf;
         if (i_pix_stb) begin
            if (m_phase == 2) begin
               if (t_le || t_fe) begin
                  m_phase <= 0;
                  m_err   <= (m_err < 255) ? m_err + 1 : 255;
               end
            end else if (t_vf) begin
               if (m_phase == 0) begin
                  m_phase <= 1;
                  m_good  <= 0;
               end else if (!t_fe && !m_bad) begin
                  m_good <= m_good + 1;
                  if (m_good + 1 == LF) m_phase <= 2;
               end else begin
                  m_good <= 0;
               end
            end
            m_bad <= t_vf ? 1'b0 : (m_bad || t_le);
            m_h   <= t_hf ? 0 : ((m_h < 1023) ? m_h + 1 : m_h);
            m_l   <= t_vf ? 0 : (t_hf ? ((m_l < 1023) ? m_l + 1 : m_l) : m_l);
            m_hp  <= i_hs;
            m_vp  <= i_vs;
         end
      end
   end

   // Every-cycle comparison against the reference.
   initial begin
      forever begin
         @(negedge CLK);
         if (cmp_en) begin
            vectors++;
            if (o_locked !== e_lk || o_active !== e_act || int'(o_x) != e_x ||
                int'(o_y) != e_y || o_frame_start !== m_fs || int'(o_err_cnt) != m_err) begin
               miscompares++;
               $display("FAIL cycle t=%0t got lk=%0b act=%0b x=%0d y=%0d fs=%0b err=%0d, want lk=%0b act=%0b x=%0d y=%0d fs=%0b err=%0d",
                        $time, o_locked, o_active, o_x, o_y, o_frame_start, o_err_cnt,
                        e_lk, e_act, e_x, e_y, m_fs, m_err);
            end
         end
      end
   end

   initial begin
      #5ms;
      miscompares++;
      $display("FAIL watchdog: time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   logic r_fs_last;
   int   pv = -1, ph = -1;
   int   p_locked, p_err, p_active, p_fs;
   bit   chk_coords = 1'b0, gate_en = 1'b0;

   task automatic pixel(input logic hs, input logic vs);
      i_hs = hs; i_vs = vs; i_pix_stb = 1'b1;
      @(posedge CLK); #1;
      r_fs_last = o_frame_start;
      i_pix_stb = 1'b0;
      for (int k = 1; k < gap; k++) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic frame(input int short_v, input int stuck_v);
      for (int v = 0; v < VT; v++) begin
         int len;
         len = (v == short_v) ? HT - 2 : HT;
         for (int h = 0; h < len; h++) begin
            pixel((v == stuck_v) ? 1'b1 : (h >= HS), (v >= VS));
            if (v == pv && h == ph) begin
               p_locked = int'(o_locked); p_err = int'(o_err_cnt);
               p_active = int'(o_active); p_fs = int'(r_fs_last);
            end
            if (chk_coords) begin
               if (v == 2 && h == 3) begin
                  chk("first_px_active", int'(o_active), 1);
                  chk("first_px_x", int'(o_x), 0);
                  chk("first_px_y", int'(o_y), 0);
               end
               if (v == 4 && h == 6) begin
                  chk("last_px_x", int'(o_x), 3);
                  chk("last_px_y", int'(o_y), 2);
               end
               if (v == 2 && h == 7) begin
                  chk("h_porch_active", int'(o_active), 0);
                  chk("h_porch_x", int'(o_x), 0);
               end
               if (v == 5 && h == 3) chk("v_porch_active", int'(o_active), 0);
            end
            if (gate_en && v == 2 && h == 4) begin
               repeat (100) @(posedge CLK);
               #1;
               chk("gate_x", int'(o_x), 1);
               chk("gate_y", int'(o_y), 0);
               chk("gate_locked", int'(o_locked), 1);
            end
         end
      end
   endtask

   initial begin
      RST_BTN = 1'b1; i_pix_stb = 1'b0; i_hs = 1'b0; i_vs = 1'b0;
      #2 RST_BTN = 1'b0;
      cmp_en = 1'b1;
      repeat (3) @(posedge CLK);
      #3;
      chk("rst_locked", int'(o_locked), 0);
      chk("rst_err", int'(o_err_cnt), 0);
      RST_BTN = 1'b1;
      pixel(1'b0, 1'b0);
      chk("rel_low_fs", int'(r_fs_last), 0);
      pixel(1'b0, 1'b0);
      chk("rel_low_locked", int'(o_locked), 0);
      pixel(1'b1, 1'b1);

      // Lock acquisition at 1 strobe per 4 CLK
      pv = 0; ph = 0;
      frame(-1, -1);
      chk("vs1_fs", p_fs, 1);
      chk("vs1_locked", p_locked, 0);
      frame(-1, -1);
      chk("vs2_fs", p_fs, 1);
      chk("vs2_locked", p_locked, 0);
      chk_coords = 1'b1;
      frame(-1, -1);
      chk_coords = 1'b0;
      chk("vs3_locked", p_locked, 1);
      chk("vs3_fs", p_fs, 1);
      chk("vs3_err", p_err, 0);

      // Short line while locked
      pv = 3; ph = 0;
      frame(2, -1);
      chk("short_locked", p_locked, 0);
      chk("short_err", p_err, 1);
      chk("short_active", p_active, 0);
      pv = 0; ph = 0;
      frame(-1, -1);
      chk("relock1_locked", p_locked, 0);
      frame(-1, -1);
      chk("relock2_locked", p_locked, 0);
      gate_en = 1'b1;
      frame(-1, -1);
      gate_en = 1'b0;
      chk("relock3_locked", p_locked, 1);

      // HS and VS falling together at lcnt=V_TOTAL-1 keeps lock
      chk_coords = 1'b1;
      frame(-1, -1);
      chk_coords = 1'b0;
      chk("simul_locked", p_locked, 1);
      chk("simul_err", p_err, 1);

      // HS stuck high for a line
      pv = 2; ph = 0;
      frame(-1, 2);
      chk("stuck_locked", p_locked, 0);
      chk("stuck_err", p_err, 2);

      // Repeated losses until the counter saturates
      gap = 1; pv = -1; ph = -1;
      for (int i = 0; i < 255; i++) begin
         frame(-1, -1);
         frame(-1, -1);
         frame(-1, 2);
      end
      chk("sat_err", int'(o_err_cnt), 255);

      // Relock, then asynchronous reset mid-frame
      gap = 4; pv = 0; ph = 0;
      frame(-1, -1);
      frame(-1, -1);
      frame(-1, -1);
      chk("final_relock", p_locked, 1);
      for (int v = 0; v < 3; v++)
         for (int h = 0; h < HT; h++)
            pixel((h >= HS), (v >= VS));
      chk("pre_rst_locked", int'(o_locked), 1);
      #2 RST_BTN = 1'b0;
      #1;
      chk("midrst_locked", int'(o_locked), 0);
      chk("midrst_err", int'(o_err_cnt), 0);
      chk("midrst_active", int'(o_active), 0);
      chk("midrst_x", int'(o_x), 0);
      chk("midrst_y", int'(o_y), 0);
      i_hs = 1'b0; i_vs = 1'b0;
      #3 RST_BTN = 1'b1;
      pixel(1'b0, 1'b0);
      chk("rel2_fs", int'(r_fs_last), 0);
      chk("rel2_locked", int'(o_locked), 0);
      pixel(1'b0, 1'b0);

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
